// File: rtl/data_mem_responder.sv
// Memory-side responder for the load/store port: one request at a time over valid/ready,
// fixed-latency response, internal little-endian word RAM with byte/half/word lanes.
// Lane logic assumes four byte lanes per word, i.e. DATA_WIDTH = 32.
module data_mem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_type,
  input  logic                  req_sign_ext,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [63:0] AddrLimit = 64'(DEPTH_WORDS) * 64'd4;

  localparam logic [1:0] TypeWord = 2'b00;
  localparam logic [1:0] TypeHalf = 2'b01;
  localparam logic [1:0] TypeByte = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Captured request
  logic                  write_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            type_q;
  logic                  sign_ext_q;

  // Registered response
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Request being resolved this cycle
  logic                  cur_write;
  logic [DATA_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [1:0]            cur_type;
  logic                  cur_sign_ext;

  logic                  capture;
  logic                  enter_resp;
  logic                  cur_err;
  logic [IdxW-1:0]       cur_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [DATA_WIDTH-1:0] load_val;
  logic [3:0]            byte_en;
  logic [DATA_WIDTH-1:0] wr_rep;
  logic [DATA_WIDTH-1:0] merged;

  // With LATENCY=1 the response is resolved on the accept edge, before the capture
  // registers load, so the live request is used while idle.
  always_comb begin
    if (state_q == StIdle) begin
      cur_write    = req_write;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
      cur_type     = req_type;
      cur_sign_ext = req_sign_ext;
    end else begin
      cur_write    = write_q;
      cur_addr     = addr_q;
      cur_wdata    = wdata_q;
      cur_type     = type_q;
      cur_sign_ext = sign_ext_q;
    end
  end

  // Access error: reserved type, misalignment, or address beyond the RAM
  always_comb begin
    cur_err = 1'b0;
    unique case (cur_type)
      TypeWord: cur_err = (cur_addr[1:0] != 2'b00);
      TypeHalf: cur_err = cur_addr[0];
      TypeByte: cur_err = 1'b0;
      default:  cur_err = 1'b1;
    endcase
    if (64'(cur_addr) >= AddrLimit) begin
      cur_err = 1'b1;
    end
  end

  assign cur_idx = cur_addr[IdxW+1:2];
  assign rd_word = mem[cur_idx];

  // Load lane selection and extension
  always_comb begin
    sel_byte = rd_word[7:0];
    unique case (cur_addr[1:0])
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    load_val = rd_word;
    unique case (cur_type)
      TypeHalf: load_val = {{(DATA_WIDTH - 16){cur_sign_ext & sel_half[15]}}, sel_half};
      TypeByte: load_val = {{(DATA_WIDTH - 8){cur_sign_ext & sel_byte[7]}}, sel_byte};
      default:  load_val = rd_word;
    endcase
  end

  // Store merge: replicate the right-aligned data across lanes, enable only the addressed ones
  always_comb begin
    byte_en = 4'b1111;
    wr_rep  = cur_wdata;
    unique case (cur_type)
      TypeHalf: begin
        byte_en = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_rep  = {2{cur_wdata[15:0]}};
      end
      TypeByte: begin
        byte_en = 4'b0001 << cur_addr[1:0];
        wr_rep  = {4{cur_wdata[7:0]}};
      end
      default: begin
        byte_en = 4'b1111;
        wr_rep  = cur_wdata;
      end
    endcase
    merged = rd_word;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = wr_rep[8*i +: 8];
      end
    end
  end

  // Next-state, latency countdown and handshake outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CntInit;
          if (LATENCY > 1) begin
            state_d = StBusy;
          end else begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
        end
      end
      StBusy: begin
        if (cnt_q == CntOne) begin
          state_d    = StResp;
          cnt_d      = '0;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= TypeWord;
      sign_ext_q <= 1'b0;
    end else if (capture) begin
      write_q    <= req_write;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      type_q     <= req_type;
      sign_ext_q <= req_sign_ext;
    end
  end

  // Response registers: set on entering RESP, held until the handshake, then cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= cur_err;
      rdata_q <= (cur_write || cur_err) ? '0 : load_val;
    end else if ((state_q == StResp) && rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  // RAM write port: stores commit on the RESP-entry edge unless errored or reset
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && cur_write && !cur_err) begin
      mem[cur_idx] <= merged;
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: three responders (LATENCY 2, 4, 1) against a byte-addressed model.
module tb_data_mem_responder;

  localparam int NDut  = 3;
  localparam int Bytes = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst          [NDut];
  logic        req_valid    [NDut];
  logic        req_ready    [NDut];
  logic        req_write    [NDut];
  logic [31:0] req_addr     [NDut];
  logic [31:0] req_wdata    [NDut];
  logic [1:0]  req_type     [NDut];
  logic        req_sign_ext [NDut];
  logic        rsp_valid    [NDut];
  logic        rsp_ready    [NDut];
  logic [31:0] rsp_rdata    [NDut];
  logic        rsp_err      [NDut];

  int          lat [NDut];
  logic [7:0]  mb  [NDut][Bytes];
  int          n_checks = 0;
  int          n_fail   = 0;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_type(req_type[0]), .req_sign_ext(req_sign_ext[0]), .rsp_valid(rsp_valid[0]),
    .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_type(req_type[1]), .req_sign_ext(req_sign_ext[1]), .rsp_valid(rsp_valid[1]),
    .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_type(req_type[2]), .req_sign_ext(req_sign_ext[2]), .rsp_valid(rsp_valid[2]),
    .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: byte-addressed memory, size/alignment/range rules, arithmetic extension.
  task automatic model_access(input int d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] typ, input bit sext,
                              output bit err, output logic [31:0] rdata);
    int size;
    int a;
    longint unsigned v;
    size  = (typ == 2'd0) ? 4 : (typ == 2'd1) ? 2 : 1;
    err   = (typ == 2'd3) || ((addr % 32'(size)) != 0) || (addr >= 32'(Bytes));
    rdata = '0;
    if (err) return;
    a = int'(addr);
    if (wr) begin
      for (int i = 0; i < size; i++) mb[d][a+i] = 8'(wdata >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < size; i++) v = v | (longint'(mb[d][a+i]) << (8 * i));
      if (sext && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
      rdata = 32'(v);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    check({tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata[d], 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err[d]), 32'd0);
  endtask

  task automatic do_txn(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] typ, input bit sext,
                        input int hold, output logic [31:0] got_rd, output logic got_err);
    int k;
    bit exp_err;
    logic [31:0] exp_rd;
    got_rd  = '0;
    got_err = 1'b0;
    k = 0;
    while (!req_ready[d] && k < 20) begin
      @(posedge clk); #1; k++;
    end
    if (!req_ready[d]) begin
      check("idle_timeout", 32'(req_ready[d]), 32'd1);
      return;
    end
    req_valid[d]    = 1'b1;
    req_write[d]    = wr;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    req_type[d]     = typ;
    req_sign_ext[d] = sext;
    @(posedge clk); #1;
    // Scramble the bus so a responder that does not capture the request shows it
    req_valid[d]    = 1'b0;
    req_write[d]    = 1'($urandom);
    req_addr[d]     = $urandom;
    req_wdata[d]    = $urandom;
    req_type[d]     = 2'($urandom);
    req_sign_ext[d] = 1'($urandom);
    k = 1;
    while (!rsp_valid[d] && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("latency", 32'(k), 32'(lat[d]));
    if (!rsp_valid[d]) return;
    model_access(d, wr, addr, wdata, typ, sext, exp_err, exp_rd);
    got_rd  = rsp_rdata[d];
    got_err = rsp_err[d];
    check("rsp_err", 32'(got_err), 32'(exp_err));
    check("rsp_rdata", got_rd, exp_rd);
    check("resp_req_ready", 32'(req_ready[d]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_rdata", rsp_rdata[d], exp_rd);
      check("hold_err", 32'(rsp_err[d]), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    check("done_valid", 32'(rsp_valid[d]), 32'd0);
    check("done_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic rand_txn(input int d);
    logic [31:0] addr;
    logic [1:0]  typ;
    logic [31:0] rd;
    logic        e;
    int          r;
    r   = $urandom_range(0, 9);
    typ = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
    if ($urandom_range(0, 9) == 0) addr = 32'(Bytes) + $urandom_range(0, 4095);
    else                           addr = $urandom_range(0, 255);
    do_txn(d, 1'($urandom), addr, $urandom, typ, 1'($urandom), $urandom_range(0, 3), rd, e);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    bit          xe;
    logic [31:0] xr;
    logic [31:0] bb_addr  [8];
    logic [31:0] bb_wdata [8];
    bit          bb_wr    [8];
    int          k;

    lat[0] = 2; lat[1] = 4; lat[2] = 1;
    for (int d = 0; d < NDut; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; req_type[d] = 2'd0; req_sign_ext[d] = 1'b0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDut; d++) rst[d] = 1'b0;
    for (int d = 0; d < NDut; d++) check_reset_outputs(d, "reset");

    // Give the first 64 words known contents in every responder
    for (int d = 0; d < NDut; d++)
      for (int w = 0; w < 64; w++) do_txn(d, 1'b1, 32'(w * 4), $urandom, 2'd0, 1'b0, 0, rd, e);

    // Word round trip
    do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 0, rd, e);
    check("st_word_err", 32'(e), 32'd0);
    check("st_word_rdata", rd, 32'd0);
    do_txn(0, 1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 0, rd, e);
    check("ld_word", rd, 32'hDEADBEEF);

    // Byte merge and extension
    do_txn(0, 1'b1, 32'h20, 32'h11223344, 2'd0, 1'b0, 0, rd, e);
    do_txn(0, 1'b1, 32'h21, 32'hFFFFFF80, 2'd2, 1'b0, 0, rd, e);
    do_txn(0, 1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 0, rd, e);
    check("merge_word", rd, 32'h11228044);
    do_txn(0, 1'b0, 32'h21, 32'h0, 2'd2, 1'b1, 0, rd, e);
    check("ld_byte_sext", rd, 32'hFFFFFF80);
    do_txn(0, 1'b0, 32'h21, 32'h0, 2'd2, 1'b0, 0, rd, e);
    check("ld_byte_zext", rd, 32'h00000080);
    do_txn(0, 1'b0, 32'h22, 32'h0, 2'd1, 1'b1, 0, rd, e);
    check("ld_half_hi", rd, 32'h00001122);

    // Errors, then RAM unchanged
    do_txn(0, 1'b0, 32'h22, 32'h0, 2'd0, 1'b0, 0, rd, e);
    check("err_word_mis", {31'd0, e}, 32'd1);
    check("err_word_mis_rd", rd, 32'd0);
    do_txn(0, 1'b1, 32'h23, 32'hFFFF, 2'd1, 1'b0, 0, rd, e);
    check("err_half_mis", {31'd0, e}, 32'd1);
    do_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 2'd3, 1'b0, 0, rd, e);
    check("err_reserved", {31'd0, e}, 32'd1);
    do_txn(0, 1'b0, 32'(Bytes), 32'h0, 2'd2, 1'b1, 0, rd, e);
    check("err_range", {31'd0, e}, 32'd1);
    check("err_range_rd", rd, 32'd0);
    do_txn(0, 1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 0, rd, e);
    check("err_no_write", rd, 32'h11228044);

    // Backpressure: hold rsp_ready low for 5 cycles
    do_txn(0, 1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 5, rd, e);
    check("bp_rdata", rd, 32'h11228044);

    // Reset while the store is in RESP: the store stays committed
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h34;
    req_wdata[0] = 32'hA5A55A5A; req_type[0] = 2'd0; req_sign_ext[0] = 1'b0;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    k = 1;
    while (!rsp_valid[0] && k < 20) begin
      @(posedge clk); #1; k++;
    end
    check("rstresp_latency", 32'(k), 32'd2);
    model_access(0, 1'b1, 32'h34, 32'hA5A55A5A, 2'd0, 1'b0, xe, xr);
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    check_reset_outputs(0, "rstresp");
    do_txn(0, 1'b0, 32'h34, 32'h0, 2'd0, 1'b0, 0, rd, e);
    check("rstresp_committed", rd, 32'hA5A55A5A);

    // Reset while a LATENCY=4 store is still busy: never committed
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h30;
    req_wdata[1] = 32'hCAFEF00D; req_type[1] = 2'd0; req_sign_ext[1] = 1'b0;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("rstbusy_valid", 32'(rsp_valid[1]), 32'd0);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    rst[1] = 1'b0;
    check_reset_outputs(1, "rstbusy");
    repeat (3) begin
      @(posedge clk); #1;
      check("rstbusy_quiet", 32'(rsp_valid[1]), 32'd0);
    end
    do_txn(1, 1'b0, 32'h30, 32'h0, 2'd0, 1'b0, 0, rd, e);
    check("rstbusy_dropped", {31'd0, rd == 32'hCAFEF00D}, 32'd0);

    // LATENCY=1 back-to-back: req_valid and rsp_ready held high, one accept per two cycles
    for (int i = 0; i < 8; i++) begin
      bb_wr[i]    = (i % 2) == 0;
      bb_addr[i]  = 32'h40 + 32'(4 * (i / 2)) + ((i % 4 == 3) ? 32'd1 : 32'd0);
      bb_wdata[i] = $urandom;
    end
    rsp_ready[2] = 1'b1;
    req_valid[2] = 1'b1; req_write[2] = bb_wr[0]; req_addr[2] = bb_addr[0];
    req_wdata[2] = bb_wdata[0]; req_type[2] = (bb_addr[0][0]) ? 2'd2 : 2'd0;
    req_sign_ext[2] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c % 2 == 0) begin
        model_access(2, bb_wr[c/2], bb_addr[c/2], bb_wdata[c/2],
                     bb_addr[c/2][0] ? 2'd2 : 2'd0, 1'b1, xe, xr);
        check("b2b_valid", 32'(rsp_valid[2]), 32'd1);
        check("b2b_busy", 32'(req_ready[2]), 32'd0);
        check("b2b_rdata", rsp_rdata[2], xr);
        check("b2b_err", 32'(rsp_err[2]), 32'(xe));
      end else begin
        check("b2b_gap_valid", 32'(rsp_valid[2]), 32'd0);
        check("b2b_gap_ready", 32'(req_ready[2]), 32'd1);
        if (c < 15) begin
          req_write[2] = bb_wr[(c+1)/2];
          req_addr[2]  = bb_addr[(c+1)/2];
          req_wdata[2] = bb_wdata[(c+1)/2];
          req_type[2]  = bb_addr[(c+1)/2][0] ? 2'd2 : 2'd0;
        end else begin
          req_valid[2] = 1'b0;
        end
      end
    end
    rsp_ready[2] = 1'b0;
    @(posedge clk); #1;
    check("b2b_no_extra", 32'(rsp_valid[2]), 32'd0);

    // Randomized traffic on all three responders
    for (int n = 0; n < 60; n++)
      for (int d = 0; d < NDut; d++) rand_txn(d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
